ysyx_25040105_mem_responder: RTL and testbench

//  - Memory-side responder for the load/store request path of the core.
//  - Accepts one word request at a time over a valid/ready channel and performs
//    the access through the DPI-C pmem_read/pmem_write functions.
//  - Returns read data or a write acknowledgement after a fixed, configurable latency.
//  - Replaces in-ALU DPI calls: the LSU becomes the initiator, this block the responder.

---
 rtl/ysyx_25040105_mem_responder_pkg.sv | 57 +++++
 rtl/ysyx_25040105_mem_responder_lat_counter.sv | 28 ++
 rtl/ysyx_25040105_mem_responder.sv | 147 ++++++++++++++
 tb/tb_ysyx_25040105_mem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040105_mem_responder_pkg.sv
// Shared definitions for the load/store request path: FSM encodings, widths,
// the address-window helper and the pmem_read/pmem_write access functions.
package ysyx_25040105_defs;

  typedef enum logic [1:0] {
    MR_IDLE   = 2'd0,
    MR_WAIT   = 2'd1,
    MR_ACCESS = 2'd2,
    MR_RESP   = 2'd3
  } mr_state_e;

  localparam int XLEN  = 32;
  localparam int MASKW = 4;

  // Backing store behind pmem_read/pmem_write; same prototypes as the
  // DPI-C entry points so the LSU and this block keep one shared view.
  localparam int          PMEM_WORDS = 1024;
  localparam logic [31:0] PMEM_BASE  = 32'h8000_0000;

  logic [XLEN-1:0] pmem [0:PMEM_WORDS-1];
  int unsigned     pmem_rd_calls;
  int unsigned     pmem_wr_calls;

  function automatic logic [9:0] pmem_index(input logic [XLEN-1:0] a);
    logic [XLEN-1:0] off;
    off = a - PMEM_BASE;
    return off[11:2];
  endfunction

  function automatic logic [XLEN-1:0] pmem_read(input logic [XLEN-1:0] raddr);
    pmem_rd_calls = pmem_rd_calls + 32'd1;
    return pmem[pmem_index(raddr)];
  endfunction

  function automatic void pmem_write(input logic [XLEN-1:0] waddr,
                                     input logic [XLEN-1:0] wdata,
                                     input logic [7:0]      wmask);
    logic [9:0] idx;
    idx = pmem_index(waddr);
    for (int b = 0; b < 4; b++) begin
      if (wmask[b]) begin
        pmem[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    pmem_wr_calls = pmem_wr_calls + 32'd1;
  endfunction

  // Wrapping subtraction makes addresses below base fail the compare too.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input logic [XLEN-1:0] base,
                                         input logic [XLEN-1:0] size);
    logic [XLEN-1:0] off;
    off = addr - base;
    return (off < size);
  endfunction

endpackage

// File: rtl/ysyx_25040105_mem_responder_lat_counter.sv
// 4-bit loadable down-counter that paces the WAIT state; last flags count==1.
module ysyx_25040105_lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] count;

  // Load on accept, otherwise count down while enabled, saturating at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end else begin
      count <= count;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/ysyx_25040105_mem_responder.sv
// Memory-side responder: accepts one word request, waits a fixed latency,
// performs the access in a single ACCESS cycle and holds the response.
module ysyx_25040105_mem_responder
  import ysyx_25040105_defs::*;
#(
  parameter int          LATENCY   = 1,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0800_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [MASKW-1:0] req_wmask,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_rdata,
  output logic             rsp_err
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
  localparam logic       DIRECT   = (LATENCY == 1);

  mr_state_e        state_q;
  mr_state_e        state_d;
  logic             cnt_load;
  logic             cnt_en;
  logic             lat_last;
  logic             accept;
  logic             wen_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [MASKW-1:0] wmask_q;
  logic [XLEN-1:0]  rdata_q;
  logic             err_q;

  assign req_ready = (state_q == MR_IDLE);
  assign rsp_valid = (state_q == MR_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  ysyx_25040105_lat_counter u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LAT_LOAD),
    .last     (lat_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and counter control.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      MR_IDLE: begin
        if (req_valid) begin
          state_d  = DIRECT ? MR_ACCESS : MR_WAIT;
          cnt_load = !DIRECT;
        end else begin
          state_d = MR_IDLE;
        end
      end
      MR_WAIT: begin
        cnt_en = 1'b1;
        if (lat_last) begin
          state_d = MR_ACCESS;
        end else begin
          state_d = MR_WAIT;
        end
      end
      MR_ACCESS: begin
        state_d = MR_RESP;
      end
      MR_RESP: begin
        if (rsp_ready) begin
          state_d = MR_IDLE;
        end else begin
          state_d = MR_RESP;
        end
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase
  end

  // Request capture; the ports are not consulted again until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr & 32'hFFFF_FFFC;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end else begin
      wen_q   <= wen_q;
      addr_q  <= addr_q;
      wdata_q <= wdata_q;
      wmask_q <= wmask_q;
    end
  end

  // Memory access: only in ACCESS and never under reset; result held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (state_q == MR_ACCESS) begin
      if (!addr_in_range(addr_q, ADDR_BASE, ADDR_SIZE)) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b1;
      end else if (wen_q) begin
        if (wmask_q != 4'd0) begin
          pmem_write(addr_q, wdata_q, {4'b0000, wmask_q});
        end
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= pmem_read(addr_q);
        err_q   <= 1'b0;
      end
    end else begin
      rdata_q <= rdata_q;
      err_q   <= err_q;
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 3, 4) share inputs and the memory model.
module tb_ysyx_25040105_mem_responder;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } sb_entry_t;

  logic        clk;
  logic        rst;
  logic        rsp_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic [2:0]  req_valid_v;
  logic [2:0]  req_ready_v;
  logic [2:0]  rsp_valid_v;
  logic [2:0]  rsp_err_v;
  logic [31:0] rsp_rdata_v [3];

  sb_entry_t sb[$];
  int total = 0;
  int bad   = 0;
  int rd0, wr0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040105_mem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[0]), .req_ready(req_ready_v[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[0]),
    .rsp_err(rsp_err_v[0]));

  ysyx_25040105_mem_responder #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[1]), .req_ready(req_ready_v[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[1]),
    .rsp_err(rsp_err_v[1]));

  ysyx_25040105_mem_responder #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid_v[2]), .req_ready(req_ready_v[2]),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[2]),
    .rsp_err(rsp_err_v[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    sb_entry_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (rsp_valid_v[i] && rsp_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: unexpected response from dut %0d", i);
          end else begin
            e = sb.pop_front();
            chk("rsp_dut", 32'(i), 32'(e.idx));
            chk("rsp_rdata", rsp_rdata_v[i], e.rdata);
            chk("rsp_err", 32'(rsp_err_v[i]), 32'(e.err));
          end
        end
      end
    end
  end

  // One full request: checks IDLE ready, latency to rsp_valid, then handshakes.
  task automatic do_req(input int idx, input int lat, input logic wen,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int cnt;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready_v[idx]), 32'd1);
    req_valid_v[idx] = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    sb.push_back('{idx: idx, rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    #1;
    req_valid_v[idx] = 1'b0;
    req_addr  = 32'hFFFF_FFF0;
    req_wdata = 32'h5A5A_5A5A;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (rsp_valid_v[idx]) break;
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(lat));
    @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid_v = 3'b000;
    req_wen = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    req_wmask = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", 32'(req_ready_v[i]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid_v[i]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_v[i], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err_v[i]), 32'd0);
    end

    // Fill memory through the port with full-mask stores (LATENCY=1)
    do_req(0, 1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0);
    do_req(0, 1, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 32'd0, 1'b0);
    do_req(0, 1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0);
    do_req(0, 1, 1'b1, 32'h87FF_FFFC, 32'h0BAD_F00D, 4'hF, 32'd0, 1'b0);
    chk("pmem_fill", ysyx_25040105_defs::pmem[1], 32'hDEAD_BEEF);

    // LATENCY=1 load; low address bits ignored
    rd0 = int'(ysyx_25040105_defs::pmem_rd_calls);
    do_req(0, 1, 1'b0, 32'h8000_0006, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    chk("rd_calls_load", 32'(int'(ysyx_25040105_defs::pmem_rd_calls) - rd0), 32'd1);

    // LATENCY=3 partial store of byte 1, then read back
    wr0 = int'(ysyx_25040105_defs::pmem_wr_calls);
    do_req(1, 3, 1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 32'd0, 1'b0);
    chk("wr_calls_store", 32'(int'(ysyx_25040105_defs::pmem_wr_calls) - wr0), 32'd1);
    chk("pmem_byte1", ysyx_25040105_defs::pmem[4], 32'h1122_AB44);
    do_req(1, 3, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 32'h1122_AB44, 1'b0);

    // Window boundaries
    rd0 = int'(ysyx_25040105_defs::pmem_rd_calls);
    do_req(1, 3, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 32'd0, 1'b1);
    do_req(1, 3, 1'b0, 32'h8800_0000, 32'd0, 4'h0, 32'd0, 1'b1);
    chk("rd_calls_err", 32'(int'(ysyx_25040105_defs::pmem_rd_calls) - rd0), 32'd0);
    do_req(1, 3, 1'b0, 32'h87FF_FFFC, 32'd0, 4'h0, 32'h0BAD_F00D, 1'b0);

    // Backpressure: rsp_ready low, next request held on the port meanwhile
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_ready_idle", 32'(req_ready_v[1]), 32'd1);
    req_valid_v[1] = 1'b1;
    req_wen   = 1'b0;
    req_addr  = 32'h8000_0010;
    sb.push_back('{idx: 1, rdata: 32'h1122_AB44, err: 1'b0});
    @(posedge clk);
    #1;
    req_addr = 32'h8000_0004;
    sb.push_back('{idx: 1, rdata: 32'hDEAD_BEEF, err: 1'b0});
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (rsp_valid_v[1]) break;
      cnt++;
    end
    chk("bp_latency", 32'(cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid_v[1]), 32'd1);
      chk("bp_hold_rdata", rsp_rdata_v[1], 32'h1122_AB44);
      chk("bp_hold_err", 32'(rsp_err_v[1]), 32'd0);
      chk("bp_req_ready_low", 32'(req_ready_v[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_hs", 32'(req_ready_v[1]), 32'd1);
    chk("bp_valid_after_hs", 32'(rsp_valid_v[1]), 32'd0);
    @(posedge clk);
    #1;
    req_valid_v[1] = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (rsp_valid_v[1]) break;
      cnt++;
    end
    chk("bp_second_latency", 32'(cnt), 32'd3);
    @(posedge clk);

    // LATENCY=4 store aborted by reset while in WAIT
    wr0 = int'(ysyx_25040105_defs::pmem_wr_calls);
    @(negedge clk);
    req_valid_v[2] = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'h1234_5678;
    req_wmask = 4'hF;
    @(posedge clk);
    #1;
    req_valid_v[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_valid", 32'(rsp_valid_v[2]), 32'd0);
    chk("rst_wait_ready", 32'(req_ready_v[2]), 32'd1);
    repeat (8) @(negedge clk);
    chk("rst_wait_no_rsp", 32'(rsp_valid_v[2]), 32'd0);
    chk("rst_wait_wr_calls", 32'(int'(ysyx_25040105_defs::pmem_wr_calls) - wr0), 32'd0);
    chk("rst_wait_mem", ysyx_25040105_defs::pmem[8], 32'hCAFE_F00D);

    // Store with empty mask: response but no write
    wr0 = int'(ysyx_25040105_defs::pmem_wr_calls);
    do_req(0, 1, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 32'd0, 1'b0);
    chk("mask0_wr_calls", 32'(int'(ysyx_25040105_defs::pmem_wr_calls) - wr0), 32'd0);
    chk("mask0_mem", ysyx_25040105_defs::pmem[1], 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
